// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MADDU = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int ITER = 32;

  // Magnitude of a 32-bit value, treating it as signed only when asked.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    mag32 = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_iter.sv
// Shared 32-step datapath: shift-add multiply and restoring divide on magnitudes.
module muldiv_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  // rem_q: partial product high half / partial remainder
  // acc_q: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [31:0] rem_q;
  logic [31:0] acc_q;
  logic [31:0] mop_q;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;

  // One iteration of either algorithm, computed combinationally.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (acc_q[0] ? {1'b0, mop_q} : 33'd0);
    div_shift = {rem_q, acc_q[31]};
    div_trial = div_shift - {1'b0, mop_q};
  end

  // Operand load at acceptance, then one shift/add or shift/subtract per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      acc_q <= '0;
      mop_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      acc_q <= opa;
      mop_q <= opb;
    end else if (step) begin
      if (is_div) begin
        // Borrow out of bit 32 means the trial subtract failed: restore.
        if (!div_trial[32]) begin
          rem_q <= div_trial[31:0];
          acc_q <= {acc_q[30:0], 1'b1};
        end else begin
          rem_q <= div_shift[31:0];
          acc_q <= {acc_q[30:0], 1'b0};
        end
      end else begin
        rem_q <= mul_sum[32:1];
        acc_q <= {mul_sum[0], acc_q[31:1]};
      end
    end
  end

  assign res_hi = rem_q;
  assign res_lo = acc_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: control FSM, sign fix-up and architectural HI/LO.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [63:0] hi_lo
);

  state_e      state;
  op_e         op_q;
  logic [31:0] a_q;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;
  logic [5:0]  cnt;

  logic        op_signed;
  logic        op_iter;
  logic        load;
  logic        step;
  logic        q_is_div;
  logic        q_is_madd;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] it_hi;
  logic [31:0] it_lo;
  logic [63:0] prod;
  logic [63:0] mac;
  logic [31:0] quo;
  logic [31:0] rmd;

  // Decode of the incoming request and of the latched operation; fix-up results.
  always_comb begin
    op_signed = ~op[0];
    op_iter   = (op != OP_MTHI) && (op != OP_MTLO);
    mag_a     = mag32(a, op_signed);
    mag_b     = mag32(b, op_signed);
    load      = (state == S_IDLE) && start && op_iter;
    q_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    q_is_madd = (op_q == OP_MADD) || (op_q == OP_MADDU);
    step      = (state == S_RUN) && !(q_is_div && b_zero);
    prod      = neg_res ? -{it_hi, it_lo} : {it_hi, it_lo};
    mac       = q_is_madd ? (prod + {hi, lo}) : prod;
    quo       = neg_res ? -it_lo : it_lo;
    rmd       = neg_rem ? -it_hi : it_hi;
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (q_is_div),
    .opa    (mag_a),
    .opb    (mag_b),
    .res_hi (it_hi),
    .res_lo (it_lo)
  );

  // Control FSM with registered busy/done/div0 and the HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div0 <= 1'b0;
            op_q <= op_e'(op);
            a_q  <= a;
            if (op == OP_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else begin
              state   <= S_RUN;
              busy    <= 1'b1;
              cnt     <= '0;
              b_zero  <= (b == 32'd0);
              neg_res <= op_signed && (a[31] ^ b[31]);
              neg_rem <= op_signed && a[31];
            end
          end
        end
        S_RUN: begin
          if (q_is_div && b_zero) begin
            // Divide by zero short-circuits without iterating.
            hi    <= a_q;
            lo    <= 32'hFFFF_FFFF;
            div0  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(ITER - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (q_is_div) begin
            hi <= rmd;
            lo <= quo;
          end else begin
            hi <= mac[63:32];
            lo <= mac[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hi_lo = {hi, lo};

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv with a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MADD = 3'd2, MADDU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  logic [63:0] hi_lo;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_div0 = 1'b0;

  // results of the most recent run_op
  int r_cyc;
  int r_busy;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo),
    .hi_lo (hi_lo)
  );

  // Architectural effect of one operation on HI/LO/div0.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m_div0 = 1'b0;
    case (o)
      MULT:  begin p = 64'(sx * sy); {m_hi, m_lo} = p; end
      MULTU: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; end
      MADD:  begin p = 64'(sx * sy) + {m_hi, m_lo}; {m_hi, m_lo} = p; end
      MADDU: begin p = ({32'd0, x} * {32'd0, y}) + {m_hi, m_lo}; {m_hi, m_lo} = p; end
      DIV, DIVU: begin
        if (y == 32'd0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF; m_div0 = 1'b1;
        end else if (o == DIV) begin
          sq = sx / sy; sr = sx % sy;
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      MTHI: m_hi = x;
      default: m_lo = x;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
    if (o == MTHI || o == MTLO) return 1;
    if ((o == DIV || o == DIVU) && y == 32'd0) return 2;
    return 34;
  endfunction

  // Issue one op at a negedge and wait (bounded) for done; ends on the done negedge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    r_cyc = -1;
    r_busy = 0;
    for (int i = 1; i <= 80; i++) begin
      if (busy) r_busy++;
      if (done) begin r_cyc = i; break; end
      @(negedge clk);
    end
    model(o, x, y);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (div0 !== 1'b0) begin n_err++; $display("FAIL reset_div0 got=%b exp=0", div0); end
    rst_n = 1'b1;
  endtask

  task automatic test_mult_timing;
    run_op(MULT, 32'hFFFF_FFFD, 32'd5);
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    n_vec++; if (r_cyc !== 34) begin n_err++; $display("FAIL mult_latency got=%0d exp=34", r_cyc); end
    n_vec++; if (r_busy !== 33) begin n_err++; $display("FAIL mult_busy_cycles got=%0d exp=33", r_busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mt_maddu;
    run_op(MTLO, 32'hFFFF_FFFF, 32'd0);
    n_vec++; if (r_cyc !== 1 || r_busy !== 0) begin n_err++; $display("FAIL mtlo_timing got=%0d/%0d exp=1/0", r_cyc, r_busy); end
    run_op(MTHI, 32'd0, 32'd0);
    n_vec++; if (hi_lo !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL mt_hilo got=%h exp=00000000ffffffff", hi_lo); end
    run_op(MADDU, 32'd1, 32'd1);
    n_vec++; if (hi !== 32'd1) begin n_err++; $display("FAIL maddu_hi got=%h exp=00000001", hi); end
    n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL maddu_lo got=%h exp=00000000", lo); end
  endtask

  task automatic test_div;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    run_op(DIVU, 32'd7, 32'd2);
    n_vec++; if (lo !== 32'd3 || hi !== 32'd1) begin n_err++; $display("FAIL divu got=%h/%h exp=1/3", hi, lo); end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_vec++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_err++; $display("FAIL div_min_neg1 got=%h/%h exp=0/80000000", hi, lo); end
  endtask

  task automatic test_div0;
    run_op(DIVU, 32'h0000_000A, 32'd0);
    n_vec++; if (hi !== 32'h0000_000A) begin n_err++; $display("FAIL div0_hi got=%h exp=0000000a", hi); end
    n_vec++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
    n_vec++; if (div0 !== 1'b1) begin n_err++; $display("FAIL div0_flag got=%b exp=1", div0); end
    n_vec++; if (r_cyc !== 2) begin n_err++; $display("FAIL div0_latency got=%0d exp=2", r_cyc); end
    run_op(MULTU, 32'd9, 32'd9);
    n_vec++; if (div0 !== 1'b0) begin n_err++; $display("FAIL div0_clear got=%b exp=0", div0); end
    n_vec++; if (lo !== 32'd81) begin n_err++; $display("FAIL div0_next_lo got=%h exp=51", lo); end
  endtask

  task automatic test_start_ignored;
    int ndone, dcyc;
    ndone = 0; dcyc = -1;
    start = 1'b1; op = MULTU; a = 32'h0001_0003; b = 32'h0000_1005;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (done) begin ndone++; if (dcyc < 0) dcyc = i; end
      if (i == 5 || i == 20) begin start = 1'b1; op = MULTU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; end
      else start = 1'b0;
      @(negedge clk);
    end
    model(MULTU, 32'h0001_0003, 32'h0000_1005);
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    n_vec++; if (dcyc !== 34) begin n_err++; $display("FAIL ignore_latency got=%0d exp=34", dcyc); end
    n_vec++; if (hi_lo !== {m_hi, m_lo}) begin n_err++; $display("FAIL ignore_result got=%h exp=%h", hi_lo, {m_hi, m_lo}); end
  endtask

  task automatic test_reset_abort;
    int ndone;
    ndone = 0;
    start = 1'b1; op = DIV; a = 32'h7FFF_0001; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
    run_op(MULTU, 32'd2, 32'd3);
    n_vec++; if (lo !== 32'd6 || hi !== 32'd0) begin n_err++; $display("FAIL abort_next got=%h/%h exp=0/6", hi, lo); end
  endtask

  task automatic test_release_start;
    rst_n = 1'b0;
    @(negedge clk);
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    rst_n = 1'b1;
    run_op(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    n_vec++; if (r_cyc !== 34) begin n_err++; $display("FAIL release_latency got=%0d exp=34", r_cyc); end
    n_vec++; if (hi_lo !== 64'd6) begin n_err++; $display("FAIL release_result got=%h exp=6", hi_lo); end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [31:0] specials [4];
    specials[0] = 32'd0; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000; specials[3] = 32'd1;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) y = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 0) y = y >> $urandom_range(0, 31);
      run_op(o, x, y);
      n_vec++;
      if (hi !== m_hi || lo !== m_lo || div0 !== m_div0) begin
        n_err++;
        $display("FAIL rand_result op=%0d a=%h b=%h got=%h_%h/%b exp=%h_%h/%b",
                 o, x, y, hi, lo, div0, m_hi, m_lo, m_div0);
      end
      n_vec++;
      if (r_cyc !== exp_lat(o, y)) begin
        n_err++;
        $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, r_cyc, exp_lat(o, y));
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_mult_timing();
    test_mt_maddu();
    test_div();
    test_div0();
    test_start_ignored();
    test_reset_abort();
    test_release_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
